// File: rtl/video_stream_monitor.sv
// In-line timing monitor for a video stage: line/frame geometry, vs-to-vs latency, sticky errors.
// Optional per-frame pixel checksum on the output side when VIDEO_STREAM_MONITOR_CHECKSUM_EN is defined.
module video_stream_monitor #(
    parameter int PIX_W = 8,
    parameter int CH    = 3,
    parameter int CNT_W = 12,
    parameter int LAT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                h_pol,
    input  logic                v_pol,
    input  logic                dv_i,
    input  logic                hs_i,
    input  logic                vs_i,
    input  logic                dv_o,
    input  logic                hs_o,
    input  logic                vs_o,
    input  logic [CH*PIX_W-1:0] pix_o,
    input  logic                clr,
    output logic [CNT_W-1:0]    line_px,
    output logic [CNT_W-1:0]    frame_ln,
    output logic [LAT_W-1:0]    latency,
    output logic                meas_valid,
    output logic [3:0]          err
`ifdef VIDEO_STREAM_MONITOR_CHECKSUM_EN
    ,
    output logic [31:0]         frame_sum,
    output logic                sum_valid
`endif
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} lat_st_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Index 0 is the stage input side, index 1 the stage output side.
    logic [1:0] act_h, act_v, dv;
    logic [1:0] act_h_q, act_h_q2, act_v_q, act_v_q2;
    logic [1:0] hs_st, vs_st, ln_lat;
    logic [1:0][CNT_W-1:0] pix_cnt_q, pix_cnt_d, ln_cnt_q, ln_cnt_d, ln_inc;
    logic [1:0][CNT_W-1:0] line_len_q, line_len_d, frame_len_q, frame_len_d;
    logic line_seen_q, frame_seen_q;

    assign act_h = {(h_pol ? hs_o : ~hs_o), (h_pol ? hs_i : ~hs_i)};
    assign act_v = {(v_pol ? vs_o : ~vs_o), (v_pol ? vs_i : ~vs_i)};
    assign dv    = {dv_o, dv_i};
    assign hs_st = act_h_q & ~act_h_q2;
    assign vs_st = act_v_q & ~act_v_q2;

    always_comb begin
        ln_lat      = '0;
        pix_cnt_d   = pix_cnt_q;
        line_len_d  = line_len_q;
        ln_inc      = ln_cnt_q;
        ln_cnt_d    = ln_cnt_q;
        frame_len_d = frame_len_q;
        for (int s = 0; s < 2; s++) begin
            ln_lat[s] = hs_st[s] && (pix_cnt_q[s] != '0);
            if (hs_st[s])
                pix_cnt_d[s] = CNT_W'(dv[s]);
            else if (dv[s])
                pix_cnt_d[s] = sat_inc(pix_cnt_q[s]);
            if (ln_lat[s]) begin
                line_len_d[s] = pix_cnt_q[s];
                ln_inc[s]     = sat_inc(ln_cnt_q[s]);
            end
            // A line closing in the same cycle as vs belongs to the frame being closed.
            ln_cnt_d[s] = vs_st[s] ? '0 : ln_inc[s];
            if (vs_st[s])
                frame_len_d[s] = ln_inc[s];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            act_h_q      <= '0;
            act_h_q2     <= '0;
            act_v_q      <= '0;
            act_v_q2     <= '0;
            pix_cnt_q    <= '0;
            ln_cnt_q     <= '0;
            line_len_q   <= '0;
            frame_len_q  <= '0;
            line_seen_q  <= 1'b0;
            frame_seen_q <= 1'b0;
        end else begin
            act_h_q      <= act_h;
            act_h_q2     <= act_h_q;
            act_v_q      <= act_v;
            act_v_q2     <= act_v_q;
            pix_cnt_q    <= pix_cnt_d;
            ln_cnt_q     <= ln_cnt_d;
            line_len_q   <= line_len_d;
            frame_len_q  <= frame_len_d;
            line_seen_q  <= line_seen_q | ln_lat[0];
            frame_seen_q <= frame_seen_q | vs_st[0];
        end
    end

    lat_st_t          st_q;
    logic [LAT_W-1:0] lat_cnt_q, latency_q, lat_inc;
    logic             have_prev_q, lat_latch;

    assign lat_inc   = (&lat_cnt_q) ? lat_cnt_q : lat_cnt_q + LAT_W'(1);
    assign lat_latch = (st_q == COUNT) && vs_st[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q        <= IDLE;
            lat_cnt_q   <= '0;
            latency_q   <= '0;
            have_prev_q <= 1'b0;
        end else begin
            case (st_q)
                IDLE, DONE: begin
                    if (vs_st[0]) begin
                        st_q      <= COUNT;
                        lat_cnt_q <= LAT_W'(1);
                    end
                end
                COUNT: begin
                    // A repeated input vs without an output vs keeps the running count.
                    if (vs_st[1]) begin
                        latency_q <= lat_cnt_q;
                        if (vs_st[0])
                            lat_cnt_q <= LAT_W'(1);
                        else
                            st_q <= DONE;
                    end else begin
                        lat_cnt_q <= lat_inc;
                    end
                end
                default: st_q <= IDLE;
            endcase
            if (lat_latch)
                have_prev_q <= 1'b1;
            else if (clr)
                have_prev_q <= 1'b0;
        end
    end

    logic [3:0] err_q, err_d, err_set;
    logic [1:0] ovs_cnt_q, ovs_cnt_d;
    logic       meas_q, meas_d, meas_set;

    always_comb begin
        err_set    = '0;
        err_set[0] = ln_lat[1] && line_seen_q && (pix_cnt_q[1] != line_len_q[0]);
        err_set[1] = vs_st[1] && frame_seen_q && (ln_inc[1] != frame_len_q[0]);
        err_set[2] = lat_latch && have_prev_q && (lat_cnt_q != latency_q);
        err_set[3] = dv_o && (act_h[1] || act_v[1]);
        err_d      = (clr ? 4'b0000 : err_q) | err_set;
        meas_set   = vs_st[1] && (ovs_cnt_q != 2'd0);
        meas_d     = meas_set || (meas_q && !clr);
        ovs_cnt_d  = clr ? 2'd0 : ovs_cnt_q;
        if (vs_st[1] && ovs_cnt_d != 2'd2)
            ovs_cnt_d = ovs_cnt_d + 2'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q     <= '0;
            meas_q    <= 1'b0;
            ovs_cnt_q <= '0;
        end else begin
            err_q     <= err_d;
            meas_q    <= meas_d;
            ovs_cnt_q <= ovs_cnt_d;
        end
    end

    assign line_px    = line_len_q[1];
    assign frame_ln   = frame_len_q[1];
    assign latency    = latency_q;
    assign meas_valid = meas_q;
    assign err        = err_q;

`ifdef VIDEO_STREAM_MONITOR_CHECKSUM_EN
    logic [31:0] pix_sum, sum_q, frame_sum_q;
    logic        sum_valid_q;

    always_comb begin
        pix_sum = '0;
        for (int c = 0; c < CH; c++)
            pix_sum = pix_sum + 32'(pix_o[c*PIX_W +: PIX_W]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q       <= '0;
            frame_sum_q <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            sum_valid_q <= vs_st[1];
            if (vs_st[1]) begin
                frame_sum_q <= sum_q;
                sum_q       <= dv_o ? pix_sum : 32'd0;
            end else if (dv_o) begin
                sum_q <= sum_q + pix_sum;
            end
        end
    end

    assign frame_sum = frame_sum_q;
    assign sum_valid = sum_valid_q;
`else
    logic unused_pix;
    assign unused_pix = ^pix_o;
`endif

endmodule

// File: tb/tb_video_stream_monitor.sv
// Directed bench for video_stream_monitor: geometry, latency, sticky errors, clr, async reset.
`timescale 1ns/1ps
module tb_video_stream_monitor;

    localparam int PIX_W = 8;
    localparam int CH    = 3;
    localparam int CNT_W = 12;
    localparam int LAT_W = 16;
    localparam int FP    = 64;
    localparam int MAXT  = 512;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic h_pol = 1'b1, v_pol = 1'b1;
    logic dv_i = 1'b0, hs_i = 1'b0, vs_i = 1'b0;
    logic dv_o = 1'b0, hs_o = 1'b0, vs_o = 1'b0;
    logic clr = 1'b0;
    logic [CH*PIX_W-1:0] pix_o = '0;
    logic [CNT_W-1:0] line_px, frame_ln;
    logic [LAT_W-1:0] latency;
    logic meas_valid;
    logic [3:0] err;
`ifdef VIDEO_STREAM_MONITOR_CHECKSUM_EN
    logic [31:0] frame_sum;
    logic sum_valid;
    int pulses;
    logic [31:0] cap;
`endif

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    logic [2:0] in_seq  [MAXT];
    logic [2:0] out_seq [MAXT];
    int run_len;

    always #5 clk = ~clk;

    video_stream_monitor #(
        .PIX_W(PIX_W), .CH(CH), .CNT_W(CNT_W), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .rst(rst), .h_pol(h_pol), .v_pol(v_pol),
        .dv_i(dv_i), .hs_i(hs_i), .vs_i(vs_i),
        .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .pix_o(pix_o),
        .clr(clr), .line_px(line_px), .frame_ln(frame_ln), .latency(latency),
        .meas_valid(meas_valid), .err(err)
`ifdef VIDEO_STREAM_MONITOR_CHECKSUM_EN
        , .frame_sum(frame_sum), .sum_valid(sum_valid)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Codes are {vs, hs, dv} at active level; pin polarity applied here.
    task automatic drive(input logic [2:0] i, input logic [2:0] o);
        dv_i = i[0];
        hs_i = h_pol ? i[1] : ~i[1];
        vs_i = v_pol ? i[2] : ~i[2];
        dv_o = o[0];
        hs_o = h_pol ? o[1] : ~o[1];
        vs_o = v_pol ? o[2] : ~o[2];
    endtask

    // Frame: vs at 0-1, four lines of 8 px (line short_ln gets 7), hs after each line.
    function automatic logic [2:0] frame_pat(input int o, input int short_ln);
        logic [2:0] r;
        r = 3'b000;
        if (o < 2) r[2] = 1'b1;
        for (int l = 0; l < 4; l++) begin
            int b;
            b = 4 + l * 14;
            if (o >= b && o < b + ((l == short_ln) ? 7 : 8)) r[0] = 1'b1;
            if (o == b + 10 || o == b + 11) r[1] = 1'b1;
        end
        return r;
    endfunction

    task automatic build(input int nfr, input int d0, input int d1, input int d2, input int short_fr);
        for (int t = 0; t < MAXT; t++) begin
            in_seq[t]  = 3'b000;
            out_seq[t] = 3'b000;
        end
        for (int f = 0; f < nfr; f++) begin
            int d;
            d = (f == 0) ? d0 : (f == 1) ? d1 : d2;
            for (int o = 0; o < FP; o++) begin
                in_seq[f*FP+o]    = frame_pat(o, -1);
                out_seq[f*FP+o+d] = frame_pat(o, (f == short_fr) ? 2 : -1);
            end
        end
        run_len = nfr * FP + 64;
    endtask

    task automatic play(input int from, input int to);
        for (int t = from; t < to; t++) begin
            @(negedge clk);
            drive(in_seq[t], out_seq[t]);
        end
    endtask

    task automatic do_reset(input logic hp, input logic vp);
        @(negedge clk);
        h_pol = hp;
        v_pol = vp;
        clr   = 1'b0;
        pix_o = '0;
        drive(3'b000, 3'b000);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic check_final(input string pfx);
        check({pfx, "_line_px"},  32'(line_px),    32'd8);
        check({pfx, "_frame_ln"}, 32'(frame_ln),   32'd4);
        check({pfx, "_latency"},  32'(latency),    32'd37);
        check({pfx, "_err"},      32'(err),        32'd0);
        check({pfx, "_meas"},     32'(meas_valid), 32'd1);
    endtask

`ifdef VIDEO_STREAM_MONITOR_CHECKSUM_EN
    function automatic logic [2:0] cs_pat(input int k);
        case (k)
            0, 14:       return 3'b100;
            3, 4, 8, 9:  return 3'b001;
            6, 11:       return 3'b010;
            default:     return 3'b000;
        endcase
    endfunction
`endif

    initial begin
        drive(3'b000, 3'b000);
        repeat (2) @(negedge clk);
        check("rst_line_px",  32'(line_px),    32'd0);
        check("rst_frame_ln", 32'(frame_ln),   32'd0);
        check("rst_latency",  32'(latency),    32'd0);
        check("rst_meas",     32'(meas_valid), 32'd0);
        check("rst_err",      32'(err),        32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Matched streams, active-high syncs
        build(3, 37, 37, 37, -1);
        play(0, 90);
        check("match_meas_early", 32'(meas_valid), 32'd0);
        check("match_lat_early",  32'(latency),    32'd37);
        play(90, run_len);
        check_final("match");

        // Same streams with active-low syncs
        do_reset(1'b0, 1'b0);
        build(3, 37, 37, 37, -1);
        play(0, run_len);
        check_final("negpol");

        // One output line short by a pixel
        do_reset(1'b1, 1'b1);
        build(3, 37, 37, 37, 1);
        play(0, run_len);
        check("drop_err", 32'(err), 32'd1);
        check("drop_line_px", 32'(line_px), 32'd8);
        pulse_clr();
        check("drop_clr_err", 32'(err), 32'd0);
        check("drop_clr_meas", 32'(meas_valid), 32'd0);

        // Latency drift 37 -> 38, then first measurement after clr is not compared
        do_reset(1'b1, 1'b1);
        build(2, 37, 38, 0, -1);
        play(0, run_len);
        check("drift_latency", 32'(latency), 32'd38);
        check("drift_err", 32'(err), 32'd4);
        pulse_clr();
        check("drift_clr_err", 32'(err), 32'd0);
        build(1, 40, 0, 0, -1);
        play(0, run_len);
        check("postclr_latency", 32'(latency), 32'd40);
        check("postclr_err", 32'(err), 32'd0);

        // dv_o during active hs_o, then async reset mid-frame
        @(negedge clk);
        drive(3'b000, 3'b011);
        @(negedge clk);
        drive(3'b000, 3'b000);
        @(negedge clk);
        check("blank_err3", 32'(err[3]), 32'd1);
        check("blank_err21", 32'(err[2:1]), 32'd0);
        build(1, 37, 0, 0, -1);
        play(0, 20);
        #2 rst = 1'b0;
        #1;
        check("arst_line_px",  32'(line_px),    32'd0);
        check("arst_frame_ln", 32'(frame_ln),   32'd0);
        check("arst_latency",  32'(latency),    32'd0);
        check("arst_meas",     32'(meas_valid), 32'd0);
        check("arst_err",      32'(err),        32'd0);
        drive(3'b000, 3'b000);
        @(negedge clk);
        rst = 1'b1;

        // Pixel counter saturates rather than wrapping
        do_reset(1'b1, 1'b1);
        for (int k = 0; k < 4100; k++) begin
            @(negedge clk);
            drive(3'b001, 3'b001);
        end
        @(negedge clk);
        drive(3'b010, 3'b010);
        repeat (3) begin
            @(negedge clk);
            drive(3'b000, 3'b000);
        end
        check("sat_line_px", 32'(line_px), 32'hFFF);
        check("sat_err", 32'(err), 32'd0);

`ifdef VIDEO_STREAM_MONITOR_CHECKSUM_EN
        // 2x2 output frame, every channel 0x10
        do_reset(1'b1, 1'b1);
        pix_o = 24'h101010;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            drive(3'b000, cs_pat(k));
        end
        pulses = 0;
        cap    = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive(3'b000, 3'b000);
            if (sum_valid) begin
                pulses++;
                cap = frame_sum;
            end
        end
        check("cs_pulses", 32'(pulses), 32'd1);
        check("cs_sum", cap, 32'h000000C0);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
